// File: rtl/move_select.sv
// Column-drop move selector: cursor steering, per-column fill tracking and a
// valid/ack handshake that offers one move at a time to a downstream board writer.
module move_select #(
  parameter int COLS = 7,
  parameter int ROWS = 6
) (
  input  logic       CLOCK,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  input  logic       drop,
  input  logic       freeze,
  input  logic       move_ack,
  output logic [2:0] cursor,
  output logic       move_valid,
  output logic [2:0] move_col,
  output logic [2:0] move_row,
  output logic       player,
  output logic       col_full_err,
  output logic       board_full
);

  localparam logic [2:0] LAST_COL = 3'(COLS - 1);
  localparam logic [2:0] ROWS_L   = 3'(ROWS);

  typedef enum logic {SELECT, OFFER} state_t;

  state_t     state_q;
  logic [2:0] cursor_q;
  logic [2:0] cnt_q [COLS];
  logic       player_q;
  logic       move_valid_q;
  logic [2:0] move_col_q;
  logic [2:0] move_row_q;
  logic       col_full_err_q;
  logic       board_full_q;

  logic [COLS-1:0] col_full;
  logic            cur_full;

  generate
    for (genvar gi = 0; gi < COLS; gi++) begin : g_full
      assign col_full[gi] = (cnt_q[gi] == ROWS_L);
    end
  endgenerate

  assign cur_full = col_full[cursor_q];

  always_ff @(posedge CLOCK) begin
    if (reset) begin
      state_q        <= SELECT;
      cursor_q       <= 3'd0;
      for (int i = 0; i < COLS; i++) cnt_q[i] <= 3'd0;
      player_q       <= 1'b0;
      move_valid_q   <= 1'b0;
      move_col_q     <= 3'd0;
      move_row_q     <= 3'd0;
      col_full_err_q <= 1'b0;
      board_full_q   <= 1'b0;
    end else begin
      col_full_err_q <= 1'b0;
      board_full_q   <= &col_full;
      case (state_q)
        SELECT: begin
          // drop wins over steering; a simultaneous left+right cancels out
          if (!freeze) begin
            if (drop) begin
              if (cur_full || board_full_q) begin
                col_full_err_q <= 1'b1;
              end else begin
                move_col_q   <= cursor_q;
                move_row_q   <= cnt_q[cursor_q];
                move_valid_q <= 1'b1;
                state_q      <= OFFER;
              end
            end else if (left && !right) begin
              cursor_q <= (cursor_q == 3'd0) ? LAST_COL : cursor_q - 3'd1;
            end else if (right && !left) begin
              cursor_q <= (cursor_q == LAST_COL) ? 3'd0 : cursor_q + 3'd1;
            end
          end
        end
        OFFER: begin
          // freeze does not cancel a pending offer
          if (move_ack) begin
            cnt_q[move_col_q] <= cnt_q[move_col_q] + 3'd1;
            player_q          <= ~player_q;
            move_valid_q      <= 1'b0;
            state_q           <= SELECT;
          end
        end
        default: state_q <= SELECT;
      endcase
    end
  end

  assign cursor       = cursor_q;
  assign move_valid   = move_valid_q;
  assign move_col     = move_col_q;
  assign move_row     = move_row_q;
  assign player       = player_q;
  assign col_full_err = col_full_err_q;
  assign board_full   = board_full_q;

endmodule

// File: tb/tb_move_select.sv
// Scoreboard bench for move_select: stimulus pushes expected offers/rejects,
// a monitor pops them when the DUT raises move_valid or col_full_err.
module tb_move_select;

  logic       CLOCK = 1'b0;
  logic       reset = 1'b1;
  logic       left = 1'b0, right = 1'b0, drop = 1'b0, freeze = 1'b0, move_ack = 1'b0;
  logic [2:0] cursor, move_col, move_row;
  logic       move_valid, player, col_full_err, board_full;

  move_select #(.COLS(7), .ROWS(6)) dut (
    .CLOCK(CLOCK), .reset(reset), .left(left), .right(right), .drop(drop),
    .freeze(freeze), .move_ack(move_ack), .cursor(cursor), .move_valid(move_valid),
    .move_col(move_col), .move_row(move_row), .player(player),
    .col_full_err(col_full_err), .board_full(board_full)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    bit is_err;
    int col;
    int row;
    int ply;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // reference model state
  int m_cnt[7];
  int m_cur = 0;
  int m_ply = 0;
  int m_off_col = 0;
  int m_off_row = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic press(input logic l, input logic r, input logic d);
    left = l; right = r; drop = d;
    tick();
    left = 1'b0; right = 1'b0; drop = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 7; i++) m_cnt[i] = 0;
    m_cur = 0;
    m_ply = 0;
  endtask

  task automatic step_right();
    press(1'b0, 1'b1, 1'b0);
    m_cur = (m_cur + 1) % 7;
  endtask

  task automatic step_left();
    press(1'b1, 1'b0, 1'b0);
    m_cur = (m_cur + 6) % 7;
  endtask

  // Drop at the model cursor; expectation goes to the scoreboard first.
  task automatic do_drop(input logic with_right);
    exp_t e;
    bit   ok;
    ok = (m_cnt[m_cur] < 6);
    e.is_err = !ok;
    e.col    = m_cur;
    e.row    = m_cnt[m_cur];
    e.ply    = m_ply;
    sb.push_back(e);
    if (ok) begin
      m_off_col = m_cur;
      m_off_row = m_cnt[m_cur];
    end
    press(1'b0, with_right, 1'b1);
    chk("cursor_hold_on_drop", int'(cursor), m_cur);
    chk("drop_valid", int'(move_valid), int'(ok));
    chk("drop_err", int'(col_full_err), int'(!ok));
    if (!ok) begin
      chk("err_player_kept", int'(player), m_ply);
      tick();
      chk("err_one_cycle", int'(col_full_err), 0);
      chk("err_no_valid", int'(move_valid), 0);
    end
  endtask

  task automatic do_ack(input int hold);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", int'(move_valid), 1);
      chk("hold_col", int'(move_col), m_off_col);
      chk("hold_row", int'(move_row), m_off_row);
    end
    move_ack = 1'b1;
    tick();
    move_ack = 1'b0;
    m_cnt[m_off_col]++;
    m_ply ^= 1;
    chk("ack_valid_low", int'(move_valid), 0);
    chk("ack_player", int'(player), m_ply);
  endtask

  // Monitor: one scoreboard entry per offer start or reject pulse.
  initial begin : monitor
    logic mv_prev;
    exp_t e;
    mv_prev = 1'b0;
    forever begin
      @(posedge CLOCK);
      #1;
      if ((move_valid && !mv_prev) || col_full_err) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_event", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("sb_kind_err", int'(col_full_err), int'(e.is_err));
          if (!e.is_err) begin
            chk("sb_col", int'(move_col), e.col);
            chk("sb_row", int'(move_row), e.row);
            chk("sb_player", int'(player), e.ply);
          end
          $display("txn: err=%0d col=%0d row=%0d player=%0d", col_full_err, move_col, move_row, player);
        end
      end
      mv_prev = move_valid;
    end
  end

  initial begin
    model_reset();
    tick(); tick();
    reset = 1'b0;
    chk("rst_cursor", int'(cursor), 0);
    chk("rst_valid", int'(move_valid), 0);
    chk("rst_player", int'(player), 0);
    chk("rst_col", int'(move_col), 0);
    chk("rst_row", int'(move_row), 0);
    chk("rst_err", int'(col_full_err), 0);
    chk("rst_bfull", int'(board_full), 0);

    // wrap and tie
    step_left();
    chk("wrap_left", int'(cursor), 6);
    step_right();
    chk("wrap_right", int'(cursor), 0);
    press(1'b1, 1'b1, 1'b0);
    chk("left_right_tie", int'(cursor), 0);

    // handshake at column 3
    step_right(); step_right(); step_right();
    chk("cursor_3", int'(cursor), 3);
    do_drop(1'b0);
    chk("hs_col", int'(move_col), 3);
    chk("hs_row", int'(move_row), 0);
    chk("hs_player", int'(player), 0);
    do_ack(5);
    chk("hs_player_after", int'(player), 1);
    do_drop(1'b0);
    chk("hs_second_row", int'(move_row), 1);
    do_ack(0);

    // drop beats right; steering ignored during offer
    do_drop(1'b1);
    chk("prio_col", int'(move_col), 3);
    chk("prio_row", int'(move_row), 2);
    press(1'b1, 1'b0, 1'b0);
    chk("offer_ignores_left", int'(cursor), 3);
    chk("offer_still_valid", int'(move_valid), 1);
    do_ack(0);

    // fill column 0, then reject
    step_left(); step_left(); step_left();
    chk("cursor_0", int'(cursor), 0);
    for (int i = 0; i < 6; i++) begin
      do_drop(1'b0);
      do_ack(0);
    end
    do_drop(1'b0);

    // freeze blocks presses but not a pending ack
    step_right();
    freeze = 1'b1;
    press(1'b0, 1'b0, 1'b1);
    chk("freeze_no_valid", int'(move_valid), 0);
    chk("freeze_no_err", int'(col_full_err), 0);
    press(1'b0, 1'b1, 1'b0);
    chk("freeze_no_move", int'(cursor), 1);
    freeze = 1'b0;
    do_drop(1'b0);
    freeze = 1'b1;
    do_ack(1);
    freeze = 1'b0;

    // reset mid-offer discards the move
    do_drop(1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    chk("midrst_valid", int'(move_valid), 0);
    chk("midrst_player", int'(player), 0);
    chk("midrst_cursor", int'(cursor), 0);
    do_drop(1'b0);
    chk("midrst_count0", int'(move_row), 0);
    do_ack(0);

    // fill the whole board
    for (int c = 0; c < 7; c++) begin
      while (m_cnt[m_cur] < 6) begin
        do_drop(1'b0);
        do_ack(0);
      end
      if (c < 6) step_right();
    end
    chk("bfull_not_yet", int'(board_full), 0);
    tick();
    chk("bfull_set", int'(board_full), 1);
    do_drop(1'b0);
    step_right(); step_right();
    do_drop(1'b0);
    chk("bfull_held", int'(board_full), 1);

    tick(); tick();
    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/move_select.md
MOVE_SELECT -- requirements
Module: move_select

Interface
REQ-001 Parameter COLS, default 7, number of board columns (2..8).
REQ-002 Parameter ROWS, default 6, number of board rows (2..7).
REQ-003 CLOCK  in  1  single clock; all state updates on posedge CLOCK.
REQ-004 reset  in  1  reset, synchronous and active-high.
REQ-005 left  in  1  single-cycle press pulse; move cursor left.
REQ-006 right  in  1  single-cycle press pulse; move cursor right.
REQ-007 drop  in  1  single-cycle press pulse; commit piece in cursor column.
REQ-008 freeze  in  1  level; game over, all press pulses ignored while high.
REQ-009 move_ack  in  1  downstream board writer accepted current move.
REQ-010 cursor  out  3  current cursor column, 0..COLS-1.
REQ-011 move_valid  out  1  move offered to downstream; held until acknowledged.
REQ-012 move_col  out  3  column of offered move.
REQ-013 move_row  out  3  landing row of offered move; 0 = bottom.
REQ-014 player  out  1  player to move; also the player of the offered move while move_valid=1.
REQ-015 col_full_err  out  1  one-cycle pulse: drop rejected, column full.
REQ-016 board_full  out  1  level; every column holds ROWS pieces.

Function
REQ-017 Block SHALL hold a per-column fill count, 0..ROWS, one register per column.
REQ-018 FSM SHALL have states SELECT and OFFER.
REQ-019 In SELECT with freeze=0, drop=1 and the count at cursor < ROWS SHALL latch move_col=cursor and move_row=count[cursor], then enter OFFER next cycle with move_valid=1.
REQ-020 In SELECT, drop=1 at a full column SHALL pulse col_full_err for exactly one cycle, remain in SELECT, and leave counts and player unchanged.
REQ-021 drop SHALL take priority over left/right in the same cycle; the cursor SHALL NOT move that cycle.
REQ-022 left=1 and right=1 in the same cycle without drop SHALL leave the cursor unchanged.
REQ-023 left alone SHALL decrement the cursor, wrapping 0 -> COLS-1; right alone SHALL increment it, wrapping COLS-1 -> 0.
REQ-024 In OFFER, move_valid, move_col and move_row SHALL stay stable until move_ack=1 is sampled.
REQ-025 On the move_ack cycle in OFFER: count[move_col] SHALL increment, player SHALL toggle, move_valid SHALL drop the next cycle, and the FSM SHALL return to SELECT.
REQ-026 left, right and drop SHALL be ignored in OFFER; move_ack SHALL be ignored in SELECT.
REQ-027 freeze=1 SHALL block new presses in SELECT but SHALL NOT cancel a pending OFFER; an ack still completes it.
REQ-028 board_full SHALL be the registered AND of (count == ROWS) over all columns and SHALL update the cycle after the final count increment.
REQ-029 When board_full=1, every drop SHALL take the col_full_err path.
REQ-030 Latency SHALL be one cycle from a drop press to move_valid=1, and one cycle from move_ack to move_valid=0.

Reset
REQ-031 reset=1 SHALL force these values on the next edge: state SELECT, cursor 0, all counts 0, player 0, move_valid 0, move_col 0, move_row 0, col_full_err 0, board_full 0.
REQ-032 reset SHALL override all other inputs, including mid-OFFER; a pending move SHALL be discarded without a count update.

Verification
REQ-033 Wrap and tie: reset, left -> cursor=6; right -> cursor=0; left+right together -> cursor unchanged.
REQ-034 Handshake: cursor=3, drop -> next cycle move_valid=1, move_col=3, move_row=0, player=0. Hold ack low 5 cycles -> outputs stable. Ack -> move_valid=0, player=1. Second drop -> move_row=1.
REQ-035 Column full: 6 acked drops in column 0, then a 7th drop -> col_full_err high for 1 cycle, no move_valid, player unchanged.
REQ-036 Priority and ignore: drop+right in the same cycle -> move_col = old cursor, cursor unchanged. left during OFFER -> cursor unchanged.
REQ-037 Board full and freeze: fill all 42 cells -> board_full=1 one cycle after the last ack, and any further drop -> col_full_err. Separately, freeze=1 in SELECT -> drop ignored; freeze=1 during OFFER followed by ack -> move completes.
REQ-038 Reset mid-OFFER: reset with move_valid=1 -> next cycle move_valid=0, all counts 0, player 0, cursor 0.
